param_scalar_rf: RTL and testbench
==================================

PARAM_SCALAR_RF -- requirements
Module: param_scalar_rf

Interface
REQ-001 The module SHALL have the parameter DATA_W, default 16, meaning register width in bits, which must be a multiple of 8.
REQ-002 The module SHALL have the parameter ADDR_W, default 4, meaning address width, with DEPTH = 2^ADDR_W registers.
REQ-003 The module SHALL have the parameter NUM_RD, default 2, meaning the number of independent read ports, range 1..4.
REQ-004 The module SHALL have the parameter ZERO_REG, default 1, where 1 means register 0 is hardwired to zero.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-006 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The module SHALL have port rd_addr, input, NUM_RD*ADDR_W bits: read addresses, with port k at bits [k*ADDR_W +: ADDR_W].
REQ-008 The module SHALL have port rd_data, output, NUM_RD*DATA_W bits: read data, with port k at bits [k*DATA_W +: DATA_W].
REQ-009 The module SHALL have port rd_busy, output, NUM_RD bits: bit k is the pending-write flag of rd_addr port k.
REQ-010 The module SHALL have port wr_en, input, 1 bit: write strobe.
REQ-011 The module SHALL have port wr_dst, input, ADDR_W bits: write destination.
REQ-012 The module SHALL have port wr_data, input, DATA_W bits: write data.
REQ-013 The module SHALL have port wr_be, input, DATA_W/8 bits: byte enables for the write.
REQ-014 The module SHALL have port rsv_en, input, 1 bit: reserve strobe, which marks rsv_dst as pending.
REQ-015 The module SHALL have port rsv_dst, input, ADDR_W bits: reservation destination.
REQ-016 The module SHALL have port flush, input, 1 bit: synchronous clear of all pending flags.
REQ-017 The module SHALL have port busy_cnt, output, ADDR_W+1 bits: the number of registers currently pending.

Function
REQ-018 The storage SHALL be DEPTH registers of DATA_W bits and a DEPTH-bit pending vector.
REQ-019 Writes SHALL occur on the rising clk edge when wr_en=1; only bytes i with wr_be[i]=1 are updated and all other bytes hold.
REQ-020 Reads SHALL be combinational with zero latency: rd_data[k] = reg[rd_addr[k]], and rd_busy[k] = pending[rd_addr[k]].
REQ-021 Write bypass: when wr_en=1 and rd_addr[k]=wr_dst in the same cycle, rd_data[k] SHALL return the merged value, i.e. enabled bytes from wr_data and the other bytes from reg.
REQ-022 Bypass SHALL NOT apply to rd_busy; rd_busy always reflects the registered pending vector.
REQ-023 When ZERO_REG=1, writes and reservations to address 0 SHALL be ignored, reads of address 0 SHALL return 0 with no bypass, and pending[0] SHALL stay 0.
REQ-024 A rising clk edge with rsv_en=1 SHALL set pending[rsv_dst].
REQ-025 A rising clk edge with wr_en=1 and wr_be non-zero SHALL clear pending[wr_dst]; wr_be=0 leaves the data and the pending flag unchanged.
REQ-026 When rsv_en and wr_en target the same register in one cycle, the data SHALL be written and pending SHALL end at 1 (reserve wins).
REQ-027 flush=1 SHALL clear the whole pending vector at the edge and override any reserve in the same cycle; a simultaneous write still updates data.
REQ-028 busy_cnt SHALL be a registered counter equal to popcount(pending) after every edge: +1 on a set of a clear flag, -1 on a clear of a set flag, net 0 when both occur on different registers, and unchanged on a reserve of an already-pending register.
REQ-029 busy_cnt SHALL be 0 after flush, and SHALL reach DEPTH (DEPTH-1 if ZERO_REG=1) without wrapping.
REQ-030 Out-of-range behaviour is not possible; all ADDR_W encodings SHALL be valid addresses.

Reset
REQ-031 rst_n=0 SHALL asynchronously set all registers to 0, pending to 0, and busy_cnt to 0, regardless of clk.
REQ-032 While rst_n=0, writes and reservations SHALL be ignored, and rd_data SHALL read 0 on all ports (bypass disabled).
REQ-033 Reset asserted mid-sequence SHALL discard all pending reservations; the first edge after deassertion SHALL behave normally.

Verification
REQ-034 Directed test, basic write and read: write reg3=0xBEEF with be=11; next cycle rd_addr0=3 -> rd_data0=0xBEEF and rd_busy0=0.
REQ-035 Directed test, byte merge and bypass: reg5=0x1234; in the same cycle write 0xABCD with be=01 and read 5 -> rd_data=0x12CD combinationally, and 0x12CD after the edge.
REQ-036 Directed test, scoreboard: reserve 7 -> rd_busy=1 and busy_cnt=1; the same cycle as a write to 7 plus a reserve of 7 -> busy stays 1 and data updates; write 7 alone -> busy=0 and busy_cnt=0.
REQ-037 Directed test, zero register: write reg0=0xFFFF and reserve 0 -> reads 0, busy 0, busy_cnt 0.
REQ-038 Directed test, flush and reset: reserve 1, 2, 3 -> busy_cnt=3; flush together with a reserve of 4 -> busy_cnt=0; then write reg9=0x55AA, pulse rst_n low between edges -> reg9 reads 0 immediately.
REQ-039 Directed test, configuration: rerun the cases above with DATA_W=32, ADDR_W=5, NUM_RD=3 and ZERO_REG=0, including a write to address 0 that is readable.

Source files
------------

// File: rtl/param_scalar_rf.sv
// Parameterised scalar register file with byte-enabled writes, write-to-read bypass
// and a per-register pending (scoreboard) vector with a registered population count.
module param_scalar_rf #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned NUM_RD   = 2,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_dst,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [DATA_W/8-1:0]        wr_be,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_dst,
    input  logic                       flush,
    output logic [ADDR_W:0]            busy_cnt
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned NB    = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_pend;
    logic [ADDR_W:0]   r_cnt;

    logic              w_wr_ok;
    logic              w_rsv_ok;
    logic [DATA_W-1:0] w_wr_merged;
    logic [DEPTH-1:0]  w_pend_d;
    logic [ADDR_W:0]   w_cnt_d;

    // Gating with rst_n also disables the bypass path while in reset.
    assign w_wr_ok  = rst_n && wr_en && (|wr_be) && !(ZERO_REG && (wr_dst == '0));
    assign w_rsv_ok = rst_n && rsv_en && !(ZERO_REG && (rsv_dst == '0));

    always_comb begin
        w_wr_merged = r_mem[wr_dst];
        for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) w_wr_merged[b*8 +: 8] = wr_data[b*8 +: 8];
        end
    end

    // Reserve is applied after the write clear so it wins on the same register.
    always_comb begin
        w_pend_d = r_pend;
        if (w_wr_ok)  w_pend_d[wr_dst]  = 1'b0;
        if (w_rsv_ok) w_pend_d[rsv_dst] = 1'b1;
        if (flush)    w_pend_d          = '0;
        w_cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_cnt_d = w_cnt_d + {{ADDR_W{1'b0}}, w_pend_d[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_pend <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_wr_ok) r_mem[wr_dst] <= w_wr_merged;
            r_pend <= w_pend_d;
            r_cnt  <= w_cnt_d;
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] w_ra;
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            w_ra = rd_addr[k*ADDR_W +: ADDR_W];
            rd_busy[k] = r_pend[w_ra];
            if (ZERO_REG && (w_ra == '0)) begin
                rd_data[k*DATA_W +: DATA_W] = '0;
            end else if (w_wr_ok && (w_ra == wr_dst)) begin
                rd_data[k*DATA_W +: DATA_W] = w_wr_merged;
            end else begin
                rd_data[k*DATA_W +: DATA_W] = r_mem[w_ra];
            end
        end
    end

    assign busy_cnt = r_cnt;

endmodule

// File: tb/tb_param_scalar_rf.sv
// Directed bench for param_scalar_rf: default configuration (instance a) and a
// 32-bit / 32-entry / 3-port / no-zero-register configuration (instance b).
module tb_param_scalar_rf;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  a_rd_addr;
    logic [31:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic        a_wr_en, a_rsv_en, a_flush;
    logic [3:0]  a_wr_dst, a_rsv_dst;
    logic [15:0] a_wr_data;
    logic [1:0]  a_wr_be;
    logic [4:0]  a_busy_cnt;

    logic [14:0] b_rd_addr;
    logic [95:0] b_rd_data;
    logic [2:0]  b_rd_busy;
    logic        b_wr_en, b_rsv_en, b_flush;
    logic [4:0]  b_wr_dst, b_rsv_dst;
    logic [31:0] b_wr_data;
    logic [3:0]  b_wr_be;
    logic [5:0]  b_busy_cnt;

    param_scalar_rf u_dut_a (
        .clk(clk), .rst_n(rst_n), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
        .rd_busy(a_rd_busy), .wr_en(a_wr_en), .wr_dst(a_wr_dst), .wr_data(a_wr_data),
        .wr_be(a_wr_be), .rsv_en(a_rsv_en), .rsv_dst(a_rsv_dst), .flush(a_flush),
        .busy_cnt(a_busy_cnt)
    );

    param_scalar_rf #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3), .ZERO_REG(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .rd_busy(b_rd_busy), .wr_en(b_wr_en), .wr_dst(b_wr_dst), .wr_data(b_wr_data),
        .wr_be(b_wr_be), .rsv_en(b_rsv_en), .rsv_dst(b_rsv_dst), .flush(b_flush),
        .busy_cnt(b_busy_cnt)
    );

    task automatic a_idle();
        a_wr_en = 0; a_rsv_en = 0; a_flush = 0; a_wr_be = '0;
    endtask

    task automatic b_idle();
        b_wr_en = 0; b_rsv_en = 0; b_flush = 0; b_wr_be = '0;
    endtask

    task automatic a_write(input logic [3:0] dst, input logic [15:0] d, input logic [1:0] be);
        a_wr_en = 1; a_wr_dst = dst; a_wr_data = d; a_wr_be = be;
    endtask

    task automatic b_write(input logic [4:0] dst, input logic [31:0] d, input logic [3:0] be);
        b_wr_en = 1; b_wr_dst = dst; b_wr_data = d; b_wr_be = be;
    endtask

    task automatic test_reset();
        rst_n = 0;
        a_idle(); a_rd_addr = '0; a_wr_dst = '0; a_wr_data = '0; a_rsv_dst = '0;
        b_idle(); b_rd_addr = '0; b_wr_dst = '0; b_wr_data = '0; b_rsv_dst = '0;
        #12;
        n_checks++; if (a_rd_data !== 32'h0) begin n_errors++; $display("FAIL reset_a_rd got %h want 0", a_rd_data); end
        n_checks++; if (a_busy_cnt !== 5'd0) begin n_errors++; $display("FAIL reset_a_cnt got %0d want 0", a_busy_cnt); end
        n_checks++; if (a_rd_busy !== 2'b00) begin n_errors++; $display("FAIL reset_a_busy got %b want 00", a_rd_busy); end
        n_checks++; if (b_rd_data !== 96'h0) begin n_errors++; $display("FAIL reset_b_rd got %h want 0", b_rd_data); end
        n_checks++; if (b_busy_cnt !== 6'd0) begin n_errors++; $display("FAIL reset_b_cnt got %0d want 0", b_busy_cnt); end
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_basic();
        @(negedge clk); a_write(4'd3, 16'hBEEF, 2'b11);
        @(negedge clk); a_idle(); a_rd_addr = {4'd3, 4'd3}; #1;
        n_checks++; if (a_rd_data[15:0] !== 16'hBEEF) begin n_errors++; $display("FAIL basic_rd0 got %h want BEEF", a_rd_data[15:0]); end
        n_checks++; if (a_rd_data[31:16] !== 16'hBEEF) begin n_errors++; $display("FAIL basic_rd1 got %h want BEEF", a_rd_data[31:16]); end
        n_checks++; if (a_rd_busy[0] !== 1'b0) begin n_errors++; $display("FAIL basic_busy0 got %b want 0", a_rd_busy[0]); end
    endtask

    task automatic test_bypass();
        @(negedge clk); a_write(4'd5, 16'h1234, 2'b11);
        @(negedge clk); a_write(4'd5, 16'hABCD, 2'b01); a_rd_addr = {4'd3, 4'd5}; #1;
        n_checks++; if (a_rd_data[15:0] !== 16'h12CD) begin n_errors++; $display("FAIL bypass_comb got %h want 12CD", a_rd_data[15:0]); end
        n_checks++; if (a_rd_data[31:16] !== 16'hBEEF) begin n_errors++; $display("FAIL bypass_other got %h want BEEF", a_rd_data[31:16]); end
        // be=0: neither data nor bypass may change anything
        @(negedge clk); a_write(4'd5, 16'hFFFF, 2'b00); #1;
        n_checks++; if (a_rd_data[15:0] !== 16'h12CD) begin n_errors++; $display("FAIL bypass_edge got %h want 12CD", a_rd_data[15:0]); end
        @(negedge clk); a_idle(); #1;
        n_checks++; if (a_rd_data[15:0] !== 16'h12CD) begin n_errors++; $display("FAIL be0_hold got %h want 12CD", a_rd_data[15:0]); end
        @(negedge clk); a_write(4'd5, 16'hABCD, 2'b10);
        @(negedge clk); a_idle(); #1;
        n_checks++; if (a_rd_data[15:0] !== 16'hABCD) begin n_errors++; $display("FAIL be10_merge got %h want ABCD", a_rd_data[15:0]); end
    endtask

    task automatic test_scoreboard();
        @(negedge clk); a_rsv_en = 1; a_rsv_dst = 4'd7; a_rd_addr = {4'd3, 4'd7};
        @(posedge clk); #1;
        n_checks++; if (a_rd_busy !== 2'b01) begin n_errors++; $display("FAIL rsv7_busy got %b want 01", a_rd_busy); end
        n_checks++; if (a_busy_cnt !== 5'd1) begin n_errors++; $display("FAIL rsv7_cnt got %0d want 1", a_busy_cnt); end
        @(negedge clk); a_write(4'd7, 16'h7777, 2'b11); #1;
        n_checks++; if (a_rd_data[15:0] !== 16'h7777) begin n_errors++; $display("FAIL wr_rsv_bypass got %h want 7777", a_rd_data[15:0]); end
        @(posedge clk); #1;
        n_checks++; if (a_rd_busy[0] !== 1'b1) begin n_errors++; $display("FAIL wr_rsv_busy got %b want 1", a_rd_busy[0]); end
        n_checks++; if (a_busy_cnt !== 5'd1) begin n_errors++; $display("FAIL wr_rsv_cnt got %0d want 1", a_busy_cnt); end
        @(negedge clk); a_rsv_en = 0; a_write(4'd7, 16'h8888, 2'b11); #1;
        n_checks++; if (a_rd_busy[0] !== 1'b1) begin n_errors++; $display("FAIL busy_no_bypass got %b want 1", a_rd_busy[0]); end
        @(posedge clk); #1;
        n_checks++; if (a_rd_busy[0] !== 1'b0) begin n_errors++; $display("FAIL wr7_busy got %b want 0", a_rd_busy[0]); end
        n_checks++; if (a_busy_cnt !== 5'd0) begin n_errors++; $display("FAIL wr7_cnt got %0d want 0", a_busy_cnt); end
        @(negedge clk); a_idle(); #1;
        n_checks++; if (a_rd_data[15:0] !== 16'h8888) begin n_errors++; $display("FAIL wr7_data got %h want 8888", a_rd_data[15:0]); end
    endtask

    task automatic test_zero();
        @(negedge clk); a_write(4'd0, 16'hFFFF, 2'b11); a_rsv_en = 1; a_rsv_dst = 4'd0;
        a_rd_addr = {4'd0, 4'd0}; #1;
        n_checks++; if (a_rd_data[15:0] !== 16'h0) begin n_errors++; $display("FAIL zero_no_bypass got %h want 0", a_rd_data[15:0]); end
        @(posedge clk); #1;
        n_checks++; if (a_rd_busy !== 2'b00) begin n_errors++; $display("FAIL zero_busy got %b want 00", a_rd_busy); end
        n_checks++; if (a_busy_cnt !== 5'd0) begin n_errors++; $display("FAIL zero_cnt got %0d want 0", a_busy_cnt); end
        @(negedge clk); a_idle(); #1;
        n_checks++; if (a_rd_data !== 32'h0) begin n_errors++; $display("FAIL zero_rd got %h want 0", a_rd_data); end
    endtask

    task automatic test_flush_reset();
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk); a_rsv_en = 1; a_rsv_dst = 4'(i);
        end
        @(posedge clk); #1;
        n_checks++; if (a_busy_cnt !== 5'd3) begin n_errors++; $display("FAIL rsv123_cnt got %0d want 3", a_busy_cnt); end
        @(negedge clk); a_rsv_dst = 4'd2;
        @(posedge clk); #1;
        n_checks++; if (a_busy_cnt !== 5'd3) begin n_errors++; $display("FAIL rsv_again_cnt got %0d want 3", a_busy_cnt); end
        @(negedge clk); a_rsv_dst = 4'd4; a_write(4'd1, 16'h1111, 2'b11); a_rd_addr = {4'd4, 4'd1};
        @(posedge clk); #1;
        n_checks++; if (a_busy_cnt !== 5'd3) begin n_errors++; $display("FAIL net0_cnt got %0d want 3", a_busy_cnt); end
        n_checks++; if (a_rd_busy !== 2'b10) begin n_errors++; $display("FAIL net0_busy got %b want 10", a_rd_busy); end
        @(negedge clk); a_flush = 1; a_rsv_dst = 4'd5; a_write(4'd6, 16'h6666, 2'b11); a_rd_addr = {4'd5, 4'd4};
        @(posedge clk); #1;
        n_checks++; if (a_busy_cnt !== 5'd0) begin n_errors++; $display("FAIL flush_cnt got %0d want 0", a_busy_cnt); end
        n_checks++; if (a_rd_busy !== 2'b00) begin n_errors++; $display("FAIL flush_busy got %b want 00", a_rd_busy); end
        @(negedge clk); a_flush = 0; a_rsv_dst = 4'd8; a_write(4'd9, 16'h55AA, 2'b11);
        @(posedge clk); #1;
        n_checks++; if (a_busy_cnt !== 5'd1) begin n_errors++; $display("FAIL rsv8_cnt got %0d want 1", a_busy_cnt); end
        @(negedge clk); a_idle(); a_rd_addr = {4'd6, 4'd9}; #1;
        n_checks++; if (a_rd_data !== 32'h666655AA) begin n_errors++; $display("FAIL pre_rst_rd got %h want 666655AA", a_rd_data); end
        #2; rst_n = 0; #1;
        n_checks++; if (a_rd_data !== 32'h0) begin n_errors++; $display("FAIL async_rst_rd got %h want 0", a_rd_data); end
        n_checks++; if (a_busy_cnt !== 5'd0) begin n_errors++; $display("FAIL async_rst_cnt got %0d want 0", a_busy_cnt); end
        a_write(4'd9, 16'h1234, 2'b11); a_rsv_en = 1; a_rsv_dst = 4'd9; #1;
        n_checks++; if (a_rd_data[15:0] !== 16'h0) begin n_errors++; $display("FAIL rst_bypass got %h want 0", a_rd_data[15:0]); end
        @(posedge clk); #1;
        n_checks++; if ({a_rd_busy, a_busy_cnt, a_rd_data} !== 39'h0) begin n_errors++; $display("FAIL rst_edge got %h want 0", {a_rd_busy, a_busy_cnt, a_rd_data}); end
        @(negedge clk); rst_n = 1; a_write(4'd10, 16'h0A0A, 2'b11); a_rsv_dst = 4'd10; a_rd_addr = {4'd9, 4'd10};
        @(posedge clk); #1;
        n_checks++; if (a_rd_busy !== 2'b01) begin n_errors++; $display("FAIL post_rst_busy got %b want 01", a_rd_busy); end
        n_checks++; if (a_busy_cnt !== 5'd1) begin n_errors++; $display("FAIL post_rst_cnt got %0d want 1", a_busy_cnt); end
        @(negedge clk); a_idle(); #1;
        n_checks++; if (a_rd_data !== 32'h00000A0A) begin n_errors++; $display("FAIL post_rst_rd got %h want 00000A0A", a_rd_data); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); a_rsv_en = 1; a_rsv_dst = 4'(i);
        end
        @(negedge clk); a_rsv_dst = 4'd15; a_rd_addr = {4'd15, 4'd0};
        @(posedge clk); #1;
        n_checks++; if (a_busy_cnt !== 5'd15) begin n_errors++; $display("FAIL fill_cnt got %0d want 15", a_busy_cnt); end
        n_checks++; if (a_rd_busy !== 2'b10) begin n_errors++; $display("FAIL fill_busy got %b want 10", a_rd_busy); end
        @(negedge clk); a_rsv_en = 0; a_flush = 1;
        @(posedge clk); #1;
        n_checks++; if (a_busy_cnt !== 5'd0) begin n_errors++; $display("FAIL fill_flush got %0d want 0", a_busy_cnt); end
        @(negedge clk); a_idle();
    endtask

    task automatic test_cfg_basic();
        @(negedge clk); b_write(5'd3, 32'hDEADBEEF, 4'hF);
        @(negedge clk); b_write(5'd0, 32'hCAFEF00D, 4'hF); b_rsv_en = 1; b_rsv_dst = 5'd0;
        b_rd_addr = {5'd3, 5'd0, 5'd3}; #1;
        n_checks++; if (b_rd_data[63:32] !== 32'hCAFEF00D) begin n_errors++; $display("FAIL cfg_r0_bypass got %h want CAFEF00D", b_rd_data[63:32]); end
        n_checks++; if (b_rd_data[95:64] !== 32'hDEADBEEF) begin n_errors++; $display("FAIL cfg_rd2 got %h want DEADBEEF", b_rd_data[95:64]); end
        @(posedge clk); #1;
        n_checks++; if (b_rd_busy !== 3'b010) begin n_errors++; $display("FAIL cfg_r0_busy got %b want 010", b_rd_busy); end
        n_checks++; if (b_busy_cnt !== 6'd1) begin n_errors++; $display("FAIL cfg_r0_cnt got %0d want 1", b_busy_cnt); end
        @(negedge clk); b_idle(); #1;
        n_checks++; if (b_rd_data[63:32] !== 32'hCAFEF00D) begin n_errors++; $display("FAIL cfg_r0_rd got %h want CAFEF00D", b_rd_data[63:32]); end
    endtask

    task automatic test_cfg_bypass();
        @(negedge clk); b_write(5'd5, 32'h11223344, 4'hF);
        @(negedge clk); b_write(5'd5, 32'hAABBCCDD, 4'b0101); b_rd_addr = {5'd3, 5'd0, 5'd5}; #1;
        n_checks++; if (b_rd_data[31:0] !== 32'h11BB33DD) begin n_errors++; $display("FAIL cfg_bypass got %h want 11BB33DD", b_rd_data[31:0]); end
        @(negedge clk); b_idle(); #1;
        n_checks++; if (b_rd_data[31:0] !== 32'h11BB33DD) begin n_errors++; $display("FAIL cfg_merge got %h want 11BB33DD", b_rd_data[31:0]); end
    endtask

    task automatic test_cfg_scoreboard();
        @(negedge clk); b_rsv_en = 1; b_rsv_dst = 5'd7; b_write(5'd7, 32'h77777777, 4'hF);
        b_rd_addr = {5'd3, 5'd0, 5'd7};
        @(posedge clk); #1;
        n_checks++; if (b_rd_busy !== 3'b011) begin n_errors++; $display("FAIL cfg_wr_rsv_busy got %b want 011", b_rd_busy); end
        n_checks++; if (b_busy_cnt !== 6'd2) begin n_errors++; $display("FAIL cfg_wr_rsv_cnt got %0d want 2", b_busy_cnt); end
        @(negedge clk); b_rsv_en = 0; b_write(5'd0, 32'h0, 4'hF);
        @(negedge clk); b_write(5'd7, 32'h87654321, 4'hF);
        @(posedge clk); #1;
        n_checks++; if (b_busy_cnt !== 6'd0) begin n_errors++; $display("FAIL cfg_clear_cnt got %0d want 0", b_busy_cnt); end
        @(negedge clk); b_idle(); #1;
        n_checks++; if (b_rd_data[31:0] !== 32'h87654321) begin n_errors++; $display("FAIL cfg_wr7 got %h want 87654321", b_rd_data[31:0]); end
        for (int i = 0; i < 32; i++) begin
            @(negedge clk); b_rsv_en = 1; b_rsv_dst = 5'(i);
        end
        @(negedge clk); b_rsv_dst = 5'd31;
        @(posedge clk); #1;
        n_checks++; if (b_busy_cnt !== 6'd32) begin n_errors++; $display("FAIL cfg_fill_cnt got %0d want 32", b_busy_cnt); end
        @(negedge clk); b_flush = 1; b_rsv_dst = 5'd4;
        @(posedge clk); #1;
        n_checks++; if (b_busy_cnt !== 6'd0) begin n_errors++; $display("FAIL cfg_flush_cnt got %0d want 0", b_busy_cnt); end
        @(negedge clk); b_idle();
    endtask

    task automatic test_cfg_reset();
        @(negedge clk); b_write(5'd9, 32'h55AA55AA, 4'hF); b_rsv_en = 1; b_rsv_dst = 5'd9;
        @(negedge clk); b_idle(); b_rd_addr = {5'd0, 5'd9, 5'd9}; #1;
        n_checks++; if (b_rd_data[31:0] !== 32'h55AA55AA) begin n_errors++; $display("FAIL cfg_pre_rst got %h want 55AA55AA", b_rd_data[31:0]); end
        #2; rst_n = 0; #1;
        n_checks++; if (b_rd_data[63:0] !== 64'h0) begin n_errors++; $display("FAIL cfg_async_rst got %h want 0", b_rd_data[63:0]); end
        n_checks++; if (b_busy_cnt !== 6'd0) begin n_errors++; $display("FAIL cfg_rst_cnt got %0d want 0", b_busy_cnt); end
        @(negedge clk); rst_n = 1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bypass();
        test_scoreboard();
        test_zero();
        test_flush_reset();
        test_fill();
        test_cfg_basic();
        test_cfg_bypass();
        test_cfg_scoreboard();
        test_cfg_reset();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule
